// File: rtl/iob_pulse_train_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : iob_pulse_train_gen                                              |
// | Brief    : Multi-channel programmable pulse-train generator. Each channel   |
// |            emits a single pulse or a train of pulses with programmable      |
// |            start delay, high duration, period and pulse count.              |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module iob_pulse_train_gen #(
   parameter int  N_CH   = 4,
   parameter int  CNT_W  = 16,
   parameter int  PCNT_W = 8,
   localparam int CH_W   = (N_CH == 1) ? 1 : $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_start,
   input  logic [CNT_W-1:0]  cfg_duration,
   input  logic [CNT_W-1:0]  cfg_period,
   input  logic [PCNT_W-1:0] cfg_count,
   input  logic              cfg_repeat,
   input  logic [N_CH-1:0]   en,
   input  logic [N_CH-1:0]   restart,
   output logic [N_CH-1:0]   pulse_out,
   output logic [N_CH-1:0]   busy,
   output logic [N_CH-1:0]   done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DELAY = 2'd1,
      S_HIGH  = 2'd2,
      S_LOW   = 2'd3
   } state_e;

   typedef struct packed {
      logic [CNT_W-1:0]  start;
      logic [CNT_W-1:0]  dur;
      logic [CNT_W-1:0]  period;
      logic [PCNT_W-1:0] count;
      logic              rep;
   } cfg_t;

   cfg_t wr_val;
   assign wr_val = '{cfg_start, cfg_duration, cfg_period, cfg_count, cfg_repeat};

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      cfg_t              act_q;      // programmed configuration
      cfg_t              sh_q, sh_d; // configuration of the running train
      state_e            state_q, state_d;
      logic [CNT_W-1:0]  cnt_q, cnt_d;
      logic [PCNT_W-1:0] pcnt_q, pcnt_d;
      logic [CNT_W-1:0]  gap;
      logic              wr_hit;
      logic              do_rise, do_fall, last, done_d;
      logic              pulse_q, busy_q, done_q;

      // Out-of-range channel numbers never match, so such writes are dropped.
      assign wr_hit = cfg_we && (cfg_ch == CH_W'(i));

      // Length of the low gap between pulses; zero when pulses abut.
      assign gap = (sh_q.period > sh_q.dur) ? (sh_q.period - sh_q.dur) : '0;

      // Active configuration register, written by the config port.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            act_q <= '0;
         end else if (wr_hit) begin
            act_q <= wr_val;
         end
      end

      // Next-state logic: a rise starts a pulse, a fall ends one. A
      // zero-width pulse rises and falls on the same edge.
      always_comb begin
         sh_d    = sh_q;
         state_d = state_q;
         cnt_d   = cnt_q;
         pcnt_d  = pcnt_q;
         done_d  = 1'b0;
         do_rise = 1'b0;
         do_fall = 1'b0;
         last    = 1'b0;
         if (!en[i]) begin
            state_d = S_IDLE;
         end else if (restart[i]) begin
            // A same-cycle write is visible to the new train.
            sh_d   = wr_hit ? wr_val : act_q;
            cnt_d  = CNT_W'(1);
            pcnt_d = '0;
            if (sh_d.start == '0) begin
               do_rise = 1'b1;
            end else begin
               state_d = S_DELAY;
            end
         end else begin
            case (state_q)
               S_DELAY: begin
                  if (cnt_q == sh_q.start) do_rise = 1'b1;
                  else                     cnt_d   = cnt_q + CNT_W'(1);
               end
               S_HIGH: begin
                  if (cnt_q == sh_q.dur) do_fall = 1'b1;
                  else                   cnt_d   = cnt_q + CNT_W'(1);
               end
               S_LOW: begin
                  if (cnt_q >= gap) do_rise = 1'b1;
                  else              cnt_d   = cnt_q + CNT_W'(1);
               end
               default: begin
                  state_d = S_IDLE;
               end
            endcase
         end

         if (do_rise) begin
            if (sh_d.dur != '0) begin
               state_d = S_HIGH;
               cnt_d   = CNT_W'(1);
            end else begin
               do_fall = 1'b1;
            end
         end

         if (do_fall) begin
            last   = !sh_d.rep ||
                     ((sh_d.count != '0) && ((pcnt_d + PCNT_W'(1)) == sh_d.count));
            pcnt_d = pcnt_d + PCNT_W'(1);
            cnt_d  = CNT_W'(1);
            if (last) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else if ((sh_d.period > sh_d.dur) || (sh_d.dur == '0)) begin
               state_d = S_LOW;
            end else begin
               state_d = S_HIGH;
            end
         end
      end

      // State, counters and registered outputs.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sh_q    <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            sh_q    <= sh_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            pulse_q <= (state_d == S_HIGH);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= done_d;
         end
      end

      assign pulse_out[i] = pulse_q;
      assign busy[i]      = busy_q;
      assign done[i]      = done_q;
   end

endmodule
`default_nettype wire
